// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: hazard sources in,
// stall/flush/forward controls and performance counters out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_reg_w_en;
  logic             ex_is_load;
  logic [4:0]       mem_rd;
  logic             mem_reg_w_en;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             cnt_clr;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_reg_w_en, ex_is_load, mem_rd, mem_reg_w_en,
    output ex_branch_taken, mem_busy, cnt_clr,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
    input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_reg_w_en, ex_is_load, mem_rd, mem_reg_w_en,
    input  ex_branch_taken, mem_busy, cnt_clr,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
    output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipe: load-use stall, branch flush
// sequencing, memory-busy freeze, registered forwarding selects, perf counters.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hif
);
  localparam int unsigned FC_W  = 3;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned REG_W = 5;

  localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'b01;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, WAIT = 2'd2} state_t;

  state_t           state_q, state_n, ret_q, ret_n, eff_state;
  logic [FC_W-1:0]  fcnt_q, fcnt_n;
  logic             pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic             id_ex_stall_c, id_ex_bubble_c, br_acc_c, load_use_c;
  logic [SEL_W-1:0] fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Youngest producer wins; x0 is never forwarded.
  function automatic logic [SEL_W-1:0] fwd_sel(
    input logic             uses,
    input logic [REG_W-1:0] rs,
    input logic             ex_w,
    input logic [REG_W-1:0] ex_rd,
    input logic             mem_w,
    input logic [REG_W-1:0] mem_rd
  );
    if (!uses)                                   return SEL_RF;
    if (ex_w && (ex_rd != '0) && (ex_rd == rs))  return SEL_MEM;
    if (mem_w && (mem_rd != '0) && (mem_rd == rs)) return SEL_WB;
    return SEL_RF;
  endfunction

  assign load_use_c = hif.ex_is_load && hif.ex_reg_w_en && (hif.ex_rd != '0) &&
                      ((hif.id_uses_rs1 && (hif.id_rs1 == hif.ex_rd)) ||
                       (hif.id_uses_rs2 && (hif.id_rs2 == hif.ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      ret_q   <= ret_n;
      fcnt_q  <= fcnt_n;
    end
  end

  // WAIT resumes the remembered state and applies its rules in the same cycle.
  always_comb begin
    state_n        = state_q;
    ret_n          = ret_q;
    fcnt_n         = fcnt_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    br_acc_c       = 1'b0;
    eff_state      = (state_q == WAIT) ? ret_q : state_q;
    if (rst) begin
      if (hif.mem_busy) begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        id_ex_stall_c = 1'b1;
        state_n       = WAIT;
        ret_n         = eff_state;
      end else begin
        state_n = eff_state;
        case (eff_state)
          FLUSH: begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            fcnt_n         = fcnt_q - FC_W'(1);
            if (fcnt_q <= FC_W'(1)) state_n = RUN;
          end
          default: begin
            if (hif.ex_branch_taken) begin
              if_id_flush_c  = 1'b1;
              id_ex_bubble_c = 1'b1;
              br_acc_c       = 1'b1;
              if (FLUSH_CYCLES > 1) begin
                state_n = FLUSH;
                fcnt_n  = FC_W'(FLUSH_CYCLES - 1);
              end
            end else if (load_use_c) begin
              pc_stall_c     = 1'b1;
              if_id_stall_c  = 1'b1;
              id_ex_bubble_c = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Forwarding selects travel with the instruction into EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
    end else if (!id_ex_stall_c) begin
      if (id_ex_bubble_c) begin
        fwd_a_q <= SEL_RF;
        fwd_b_q <= SEL_RF;
      end else begin
        fwd_a_q <= fwd_sel(hif.id_uses_rs1, hif.id_rs1, hif.ex_reg_w_en, hif.ex_rd,
                           hif.mem_reg_w_en, hif.mem_rd);
        fwd_b_q <= fwd_sel(hif.id_uses_rs2, hif.id_rs2, hif.ex_reg_w_en, hif.ex_rd,
                           hif.mem_reg_w_en, hif.mem_rd);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (hif.cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall_c && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_acc_c && (flush_cnt_q != CNT_MAX))   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hif.pc_stall     = pc_stall_c;
  assign hif.if_id_stall  = if_id_stall_c;
  assign hif.if_id_flush  = if_id_flush_c;
  assign hif.id_ex_stall  = id_ex_stall_c;
  assign hif.id_ex_bubble = id_ex_bubble_c;
  assign hif.fwd_a_sel    = fwd_a_q;
  assign hif.fwd_b_sel    = fwd_b_q;
  assign hif.stall_cnt    = stall_cnt_q;
  assign hif.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic
// against a pending-bubble reference model.
module tb_hazard_ctrl;
  localparam int unsigned FC   = 2;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif();
  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hif(hif));

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble}
  logic [4:0] ctl;
  logic [3:0] fwd;
  assign ctl = {hif.pc_stall, hif.if_id_stall, hif.if_id_flush, hif.id_ex_stall, hif.id_ex_bubble};
  assign fwd = {hif.fwd_a_sel, hif.fwd_b_sel};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bubbles still owed after a branch, plus expected registers.
  int         m_pend = 0;
  logic [1:0] m_fa = 2'b00, m_fb = 2'b00;
  int         m_sc = 0, m_fcnt = 0;

  function automatic logic load_use();
    return hif.ex_is_load && hif.ex_reg_w_en && (hif.ex_rd != 5'd0) &&
           ((hif.id_uses_rs1 && hif.id_rs1 == hif.ex_rd) ||
            (hif.id_uses_rs2 && hif.id_rs2 == hif.ex_rd));
  endfunction

  function automatic logic [4:0] exp_ctl();
    if (!rst)                                 return 5'b00000;
    if (hif.mem_busy)                         return 5'b11010;
    if (m_pend > 0 || hif.ex_branch_taken)    return 5'b00101;
    if (load_use())                           return 5'b11001;
    return 5'b00000;
  endfunction

  function automatic logic [1:0] exp_sel(input logic uses, input logic [4:0] rs);
    if (!uses) return 2'b00;
    if (hif.ex_reg_w_en && hif.ex_rd != 5'd0 && hif.ex_rd == rs) return 2'b01;
    if (hif.mem_reg_w_en && hif.mem_rd != 5'd0 && hif.mem_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_fa = 2'b00; m_fb = 2'b00; m_sc = 0; m_fcnt = 0;
  endtask

  // Advance one clock; update the model from the pre-edge inputs.
  task automatic tick();
    logic [4:0] e;
    logic [1:0] na, nb;
    logic       acc;
    int         np, nsc, nfc;
    e   = exp_ctl();
    na  = m_fa; nb = m_fb; np = m_pend; nsc = m_sc; nfc = m_fcnt;
    acc = !hif.mem_busy && m_pend == 0 && hif.ex_branch_taken;
    if (!e[1]) begin
      na = e[0] ? 2'b00 : exp_sel(hif.id_uses_rs1, hif.id_rs1);
      nb = e[0] ? 2'b00 : exp_sel(hif.id_uses_rs2, hif.id_rs2);
    end
    if (!hif.mem_busy && m_pend > 0) np = m_pend - 1;
    else if (acc) np = int'(FC) - 1;
    if (hif.cnt_clr) begin
      nsc = 0; nfc = 0;
    end else begin
      if (e[4] && nsc < CMAX) nsc++;
      if (acc && nfc < CMAX) nfc++;
    end
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      m_fa = na; m_fb = nb; m_pend = np; m_sc = nsc; m_fcnt = nfc;
    end
    #1;
  endtask

  task automatic idle();
    hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0; hif.id_uses_rs1 = 1'b0; hif.id_uses_rs2 = 1'b0;
    hif.ex_rd = 5'd0; hif.ex_reg_w_en = 1'b0; hif.ex_is_load = 1'b0;
    hif.mem_rd = 5'd0; hif.mem_reg_w_en = 1'b0;
    hif.ex_branch_taken = 1'b0; hif.mem_busy = 1'b0; hif.cnt_clr = 1'b0;
  endtask

  task automatic clear_counters();
    idle();
    hif.cnt_clr = 1'b1;
    tick();
    hif.cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    hif.mem_busy = 1'b1; hif.ex_branch_taken = 1'b1;
    hif.ex_is_load = 1'b1; hif.ex_reg_w_en = 1'b1; hif.ex_rd = 5'd4;
    hif.id_rs1 = 5'd4; hif.id_uses_rs1 = 1'b1;
    #2;
    n_checks++; if (ctl !== 5'b00000) $display("FAIL reset_ctl got=%b exp=00000", ctl); else n_pass++;
    tick(); tick();
    n_checks++; if (fwd !== 4'b0000) $display("FAIL reset_fwd got=%b exp=0000", fwd); else n_pass++;
    n_checks++; if (hif.stall_cnt !== 4'd0 || hif.flush_cnt !== 4'd0)
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hif.stall_cnt, hif.flush_cnt); else n_pass++;
    idle();
    rst = 1'b1;
    #1;
    n_checks++; if (ctl !== 5'b00000) $display("FAIL reset_release_ctl got=%b exp=00000", ctl); else n_pass++;
  endtask

  task automatic test_load_use();
    clear_counters();
    hif.ex_is_load = 1'b1; hif.ex_reg_w_en = 1'b1; hif.ex_rd = 5'd5;
    hif.id_rs1 = 5'd5; hif.id_uses_rs1 = 1'b1; hif.id_rs2 = 5'd1; hif.id_uses_rs2 = 1'b1;
    #1;
    n_checks++; if (ctl !== 5'b11001) $display("FAIL lu_stall got=%b exp=11001", ctl); else n_pass++;
    tick();
    n_checks++; if (hif.fwd_a_sel !== 2'b00) $display("FAIL lu_bubble_fwd got=%b exp=00", hif.fwd_a_sel); else n_pass++;
    n_checks++; if (hif.stall_cnt !== 4'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", hif.stall_cnt); else n_pass++;
    hif.ex_is_load = 1'b0; hif.ex_reg_w_en = 1'b0; hif.ex_rd = 5'd0;
    hif.mem_rd = 5'd5; hif.mem_reg_w_en = 1'b1;
    #1;
    n_checks++; if (ctl !== 5'b00000) $display("FAIL lu_one_cycle got=%b exp=00000", ctl); else n_pass++;
    tick();
    n_checks++; if (hif.fwd_a_sel !== 2'b10) $display("FAIL lu_wb_fwd got=%b exp=10", hif.fwd_a_sel); else n_pass++;
  endtask

  task automatic test_branch_flush();
    clear_counters();
    hif.ex_branch_taken = 1'b1;
    #1;
    n_checks++; if (ctl !== 5'b00101) $display("FAIL br_cycle1 got=%b exp=00101", ctl); else n_pass++;
    tick();
    #1;
    n_checks++; if (ctl !== 5'b00101) $display("FAIL br_cycle2 got=%b exp=00101", ctl); else n_pass++;
    tick();
    hif.ex_branch_taken = 1'b0;
    #1;
    n_checks++; if (ctl !== 5'b00000) $display("FAIL br_done got=%b exp=00000", ctl); else n_pass++;
    n_checks++; if (hif.flush_cnt !== 4'd1) $display("FAIL br_flush_cnt got=%0d exp=1", hif.flush_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_busy_in_flush();
    clear_counters();
    hif.ex_reg_w_en = 1'b1; hif.ex_rd = 5'd3; hif.id_rs1 = 5'd3; hif.id_uses_rs1 = 1'b1;
    hif.ex_branch_taken = 1'b1;
    tick();
    hif.ex_branch_taken = 1'b0; hif.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ctl !== 5'b11010) $display("FAIL busy_ctl[%0d] got=%b exp=11010", i, ctl); else n_pass++;
      tick();
      n_checks++; if (hif.fwd_a_sel !== 2'b00) $display("FAIL busy_fwd_hold[%0d] got=%b exp=00", i, hif.fwd_a_sel); else n_pass++;
    end
    hif.mem_busy = 1'b0;
    #1;
    n_checks++; if (ctl !== 5'b00101) $display("FAIL busy_resume_flush got=%b exp=00101", ctl); else n_pass++;
    tick();
    #1;
    n_checks++; if (ctl !== 5'b00000) $display("FAIL busy_flush_done got=%b exp=00000", ctl); else n_pass++;
    tick();
    n_checks++; if (hif.fwd_a_sel !== 2'b01) $display("FAIL busy_fwd_after got=%b exp=01", hif.fwd_a_sel); else n_pass++;
    n_checks++; if (hif.stall_cnt !== 4'd3) $display("FAIL busy_stall_cnt got=%0d exp=3", hif.stall_cnt); else n_pass++;
  endtask

  task automatic test_fwd_priority();
    idle();
    hif.ex_rd = 5'd7; hif.mem_rd = 5'd7; hif.ex_reg_w_en = 1'b1; hif.mem_reg_w_en = 1'b1;
    hif.id_rs1 = 5'd7; hif.id_rs2 = 5'd7; hif.id_uses_rs1 = 1'b1; hif.id_uses_rs2 = 1'b1;
    tick();
    n_checks++; if (fwd !== 4'b0101) $display("FAIL fwd_ex_wins got=%b exp=0101", fwd); else n_pass++;
    hif.ex_rd = 5'd0;
    tick();
    n_checks++; if (fwd !== 4'b1010) $display("FAIL fwd_mem got=%b exp=1010", fwd); else n_pass++;
    hif.id_rs1 = 5'd0;
    tick();
    n_checks++; if (fwd !== 4'b0010) $display("FAIL fwd_x0 got=%b exp=0010", fwd); else n_pass++;
    hif.id_rs1 = 5'd7; hif.id_uses_rs1 = 1'b0;
    tick();
    n_checks++; if (fwd !== 4'b0010) $display("FAIL fwd_unused got=%b exp=0010", fwd); else n_pass++;
  endtask

  task automatic test_async_reset();
    clear_counters();
    hif.ex_branch_taken = 1'b1;
    tick();
    hif.ex_branch_taken = 1'b0;
    #1;
    n_checks++; if (ctl !== 5'b00101) $display("FAIL arst_pre_flush got=%b exp=00101", ctl); else n_pass++;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if (ctl !== 5'b00000) $display("FAIL arst_ctl got=%b exp=00000", ctl); else n_pass++;
    n_checks++; if (hif.flush_cnt !== 4'd0 || fwd !== 4'b0000)
      $display("FAIL arst_regs got=%0d/%b exp=0/0000", hif.flush_cnt, fwd); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ctl !== 5'b00000) $display("FAIL arst_no_residual got=%b exp=00000", ctl); else n_pass++;
    tick();
    n_checks++; if (ctl !== 5'b00000) $display("FAIL arst_after_edge got=%b exp=00000", ctl); else n_pass++;
  endtask

  task automatic test_saturation();
    clear_counters();
    hif.mem_busy = 1'b1;
    repeat (20) tick();
    n_checks++; if (hif.stall_cnt !== 4'd15) $display("FAIL sat_stall_cnt got=%0d exp=15", hif.stall_cnt); else n_pass++;
    hif.cnt_clr = 1'b1;
    tick();
    n_checks++; if (hif.stall_cnt !== 4'd0) $display("FAIL sat_clr_wins got=%0d exp=0", hif.stall_cnt); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int i = 0; i < 600; i++) begin
      hif.id_rs1 = 5'($urandom_range(0, 3)); hif.id_rs2 = 5'($urandom_range(0, 3));
      hif.id_uses_rs1 = 1'($urandom); hif.id_uses_rs2 = 1'($urandom);
      hif.ex_rd = 5'($urandom_range(0, 3)); hif.ex_reg_w_en = 1'($urandom);
      hif.ex_is_load = 1'($urandom);
      hif.mem_rd = 5'($urandom_range(0, 3)); hif.mem_reg_w_en = 1'($urandom);
      hif.ex_branch_taken = ($urandom_range(0, 99) < 15);
      hif.mem_busy = ($urandom_range(0, 99) < 20);
      hif.cnt_clr = ($urandom_range(0, 99) < 3);
      #1;
      e = exp_ctl();
      n_checks++; if (ctl !== e) $display("FAIL rnd_ctl[%0d] got=%b exp=%b", i, ctl, e); else n_pass++;
      tick();
      n_checks++; if (fwd !== {m_fa, m_fb}) $display("FAIL rnd_fwd[%0d] got=%b exp=%b", i, fwd, {m_fa, m_fb}); else n_pass++;
      n_checks++; if (hif.stall_cnt !== 4'(m_sc) || hif.flush_cnt !== 4'(m_fcnt))
        $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, hif.stall_cnt, hif.flush_cnt, m_sc, m_fcnt);
      else n_pass++;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch_flush();
    test_busy_in_flush();
    test_fwd_priority();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
